// File: rtl/ks_adder_pipe_if.sv
// Valid/ready operand and result bundle for the Kogge-Stone adder pipe.
// Master is the operand source / result sink, slave is the adder.
interface ks_adder_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_cin,
    output in_sub, in_tag, out_ready,
    input  in_ready, out_valid, out_sum,
    input  out_cout, out_ovf, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin,
    input  in_sub, in_tag, out_ready,
    output in_ready, out_valid, out_sum,
    output out_cout, out_ovf, out_tag
  );
endinterface

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor, register every REG_EVERY
// prefix levels, global stall on output backpressure.
module ks_adder_pipe #(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 1,
  parameter int TAG_W     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  ks_adder_pipe_if.slave bus
);
  localparam int LEVELS = $clog2(WIDTH);
  localparam int NS =
    (LEVELS + REG_EVERY - 1) / REG_EVERY;

  logic stall;

  assign stall = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = rst_n & ~stall;

  // Register j holds the result of every level up to K(j).
  for (genvar j = 0; j <= NS; j++) begin : g_stg
    logic [WIDTH-1:0] gq, pq, hq;
    logic [WIDTH-1:0] gd, pd, hd;
    logic             cq, cd;
    logic             vq, vd;
    logic [TAG_W-1:0] tq, td;

    if (j == 0) begin : g_in
      logic [WIDTH-1:0] bx;
      assign bx = bus.in_sub ? ~bus.in_b : bus.in_b;
      assign cd = bus.in_sub | bus.in_cin;
      assign hd = bus.in_a ^ bx;
      assign pd = hd;
      assign gd = (bus.in_a & bx) |
        {{(WIDTH-1){1'b0}}, hd[0] & cd};
      assign vd = bus.in_valid;
      assign td = bus.in_tag;
    end else begin : g_mid
      localparam int K =
        (j * REG_EVERY < LEVELS) ?
        j * REG_EVERY : LEVELS;
      assign gd = g_lvl[K].go;
      assign pd = g_lvl[K].po;
      assign hd = g_stg[j-1].hq;
      assign cd = g_stg[j-1].cq;
      assign vd = g_stg[j-1].vq;
      assign td = g_stg[j-1].tq;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vq <= 1'b0;
        gq <= '0;
        pq <= '0;
        hq <= '0;
        cq <= 1'b0;
        tq <= '0;
      end else if (!stall) begin
        vq <= vd;
        gq <= gd;
        pq <= pd;
        hq <= hd;
        cq <= cd;
        tq <= td;
      end
    end
  end

  // Level k combines each bit with the one 2^(k-1) below it.
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int S  = 1 << (k - 1);
    localparam int SI = (k - 1) / REG_EVERY;
    logic [WIDTH-1:0] gi, pi, go, po;

    if ((k - 1) % REG_EVERY == 0) begin : g_reg
      assign gi = g_stg[SI].gq;
      assign pi = g_stg[SI].pq;
    end else begin : g_chain
      assign gi = g_lvl[k-1].go;
      assign pi = g_lvl[k-1].po;
    end

    always_comb begin
      go = gi;
      po = pi;
      for (int i = S; i < WIDTH; i++) begin
        go[i] = gi[i] | (pi[i] & gi[i-S]);
        po[i] = pi[i] & pi[i-S];
      end
    end
  end

  assign bus.out_valid = g_stg[NS].vq;
  assign bus.out_tag   = g_stg[NS].tq;
  assign bus.out_sum   = {
    g_stg[NS].hq[WIDTH-1:1] ^
    g_stg[NS].gq[WIDTH-2:0],
    g_stg[NS].hq[0] ^ g_stg[NS].cq
  };
  assign bus.out_cout = g_stg[NS].gq[WIDTH-1];
  assign bus.out_ovf  = g_stg[NS].gq[WIDTH-2] ^
                        g_stg[NS].gq[WIDTH-1];
endmodule

// File: tb/tb_ks_adder_pipe.sv
// Bench for ks_adder_pipe: vector table, random streams against an
// arithmetic model, backpressure, reset and a parameter sweep.
module tb_ks_adder_pipe;
  localparam int W   = 32;
  localparam int TW  = 4;
  localparam int RE  = 1;
  localparam int LAT = 6;
  localparam int NCFG = 6;
  localparam int CW [NCFG] = '{2, 7, 16, 33, 64, 32};
  localparam int CR [NCFG] = '{1, 1, 4, 2, 6, 5};

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic clk;
  logic rst_n;
  logic go;
  logic [NCFG-1:0] done;
  int tests;
  int fails;

  ks_adder_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  ks_adder_pipe #(
    .WIDTH(W), .REG_EVERY(RE), .TAG_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t ref_add(
    input int w, input logic [63:0] a,
    input logic [63:0] b, input logic ci,
    input logic su
  );
    logic [63:0] m, aa, bb, s;
    logic [64:0] t;
    res_t r;
    m  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa = a & m;
    bb = (su ? ~b : b) & m;
    t  = {1'b0, aa} + {1'b0, bb} + 65'(su | ci);
    s  = t[63:0] & m;
    r.sum  = s;
    r.cout = t[w];
    r.ovf  = (aa[w-1] == bb[w-1]) &&
             (s[w-1] != aa[w-1]);
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Parameter sweep: latency formula plus streamed results.
  for (genvar c = 0; c < NCFG; c++) begin : g_sw
    localparam int SW = CW[c];
    localparam int SR = CR[c];
    localparam int SL =
      1 + ($clog2(SW) + SR - 1) / SR;

    ks_adder_pipe_if #(.WIDTH(SW), .TAG_W(TW)) sb ();

    ks_adder_pipe #(
      .WIDTH(SW), .REG_EVERY(SR), .TAG_W(TW)
    ) sd (
      .clk(clk), .rst_n(rst_n), .bus(sb)
    );

    initial begin : sw_run
      logic [63:0] a, b;
      logic ci, su;
      logic [3:0] t;
      res_t r;
      res_t q[$];
      logic [3:0] tq[$];
      int lat, sent, got, cyc, tot;
      string nm;
      nm = $sformatf("sweep_w%0d_r%0d", SW, SR);
      sb.in_valid = 1'b0;
      sb.in_a = '0;
      sb.in_b = '0;
      sb.in_cin = 1'b0;
      sb.in_sub = 1'b0;
      sb.in_tag = '0;
      sb.out_ready = 1'b1;
      wait (go === 1'b1);
      @(negedge clk);
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      ci = 1'($urandom_range(1));
      su = 1'($urandom_range(1));
      sb.in_a = a[SW-1:0];
      sb.in_b = b[SW-1:0];
      sb.in_cin = ci;
      sb.in_sub = su;
      sb.in_tag = 4'hA;
      sb.in_valid = 1'b1;
      @(posedge clk);
      #1 sb.in_valid = 1'b0;
      lat = 1;
      while (!sb.out_valid && lat < 40) begin
        @(posedge clk);
        #1 lat++;
      end
      r = ref_add(SW, a, b, ci, su);
      chk({nm, "_lat"}, 128'(lat), 128'(SL));
      chk({nm, "_first"},
          {sb.out_sum, sb.out_cout, sb.out_ovf},
          {r.sum[SW-1:0], r.cout, r.ovf});
      @(posedge clk);
      sent = 0;
      got = 0;
      cyc = 0;
      tot = (SW == 7) ? 16384 : 200;
      while (got < tot && cyc < tot + 100) begin
        @(negedge clk);
        if (sent < tot) begin
          if (SW == 7) begin
            a = 64'(sent / 128);
            b = 64'(sent % 128);
          end else begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
          end
          ci = 1'($urandom_range(1));
          su = 1'($urandom_range(1));
          sb.in_a = a[SW-1:0];
          sb.in_b = b[SW-1:0];
          sb.in_cin = ci;
          sb.in_sub = su;
          sb.in_tag = 4'(sent);
          sb.in_valid = 1'b1;
        end else begin
          sb.in_valid = 1'b0;
        end
        #1;
        if (sb.out_valid) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s_extra: unexpected beat",
                     nm);
          end else begin
            r = q.pop_front();
            t = tq.pop_front();
            chk(nm, {sb.out_sum, sb.out_cout,
                     sb.out_ovf, sb.out_tag},
                {r.sum[SW-1:0], r.cout, r.ovf, t});
            got++;
          end
        end
        if (sb.in_valid && sb.in_ready) begin
          q.push_back(ref_add(SW, a, b, ci, su));
          tq.push_back(4'(sent));
          sent++;
        end
        cyc++;
      end
      sb.in_valid = 1'b0;
      chk({nm, "_count"}, 128'(got), 128'(tot));
      done[c] = 1'b1;
    end
  end

  task automatic beat(
    input logic [31:0] a, input logic [31:0] b,
    input logic ci, input logic su,
    input logic [3:0] tg,
    output int lat, output logic [37:0] o
  );
    bus.in_a = a;
    bus.in_b = b;
    bus.in_cin = ci;
    bus.in_sub = su;
    bus.in_tag = tg;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    o = {bus.out_sum, bus.out_cout,
         bus.out_ovf, bus.out_tag};
    @(posedge clk);
    #1;
  endtask

  // Streams nb random beats; optional stall of st_len cycles.
  task automatic stream(input int nb,
                        input int st_at,
                        input int st_len);
    res_t q[$];
    logic [3:0] tq[$];
    res_t r;
    logic [3:0] t;
    logic [31:0] a, b;
    logic ci, su, stw, hold;
    logic [37:0] snap, cur;
    int sent, got, cyc, fv, fd, ld;
    sent = 0;
    got = 0;
    cyc = 0;
    fv = -1;
    fd = -1;
    ld = -1;
    hold = 1'b0;
    a = '0;
    b = '0;
    ci = 1'b0;
    su = 1'b0;
    snap = '0;
    while (got < nb && cyc < nb + 200) begin
      @(negedge clk);
      stw = (fv >= 0) && (cyc >= fv + st_at) &&
            (cyc < fv + st_at + st_len);
      bus.out_ready = !stw;
      if (!hold) begin
        if (sent < nb) begin
          a = $urandom;
          b = $urandom;
          if ($urandom_range(7) == 0) a = '1;
          if ($urandom_range(7) == 0) b = 32'h8000_0000;
          ci = 1'($urandom_range(1));
          su = 1'($urandom_range(1));
          bus.in_a = a;
          bus.in_b = b;
          bus.in_cin = ci;
          bus.in_sub = su;
          bus.in_tag = 4'(sent);
          bus.in_valid = 1'b1;
          hold = 1'b1;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      #1;
      if (bus.out_valid && fv < 0) fv = cyc;
      cur = {bus.out_sum, bus.out_cout,
             bus.out_ovf, bus.out_tag};
      if (stw) begin
        chk("stall_in_ready", 128'(bus.in_ready), 0);
        if (cyc == fv + st_at) snap = cur;
        else chk("stall_frozen", 128'(cur), 128'(snap));
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(ref_add(32, 64'(a), 64'(b), ci, su));
        tq.push_back(4'(sent));
        sent++;
        hold = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL stream_extra: unexpected beat");
        end else begin
          r = q.pop_front();
          t = tq.pop_front();
          chk("stream_beat", 128'(cur),
              {r.sum[31:0], r.cout, r.ovf, t});
          got++;
          if (fd < 0) fd = cyc;
          ld = cyc;
        end
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_count", 128'(got), 128'(nb));
    chk("stream_span", 128'(ld - fd + 1),
        128'(nb + st_len));
  endtask

  initial begin : main
    vec_t vt [9];
    logic [37:0] o;
    int lat, guard;
    logic seen;
    tests = 0;
    fails = 0;
    go = 1'b0;
    done = '0;
    vt[0] = '{32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0,
              32'h0, 1'b1, 1'b0};
    vt[1] = '{32'h8000_0000, 32'h1, 1'b0, 1'b1,
              32'h7FFF_FFFF, 1'b1, 1'b1};
    vt[2] = '{32'h5, 32'h7, 1'b0, 1'b1,
              32'hFFFF_FFFE, 1'b0, 1'b0};
    vt[3] = '{32'h0, 32'h0, 1'b1, 1'b0,
              32'h1, 1'b0, 1'b0};
    vt[4] = '{32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0,
              32'h8000_0000, 1'b0, 1'b1};
    vt[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0,
              1'b0, 32'h0, 1'b1, 1'b1};
    vt[6] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0,
              1'b0, 32'hACF1_3568, 1'b0, 1'b0};
    vt[7] = '{32'h10, 32'h10, 1'b1, 1'b1,
              32'h0, 1'b1, 1'b0};
    vt[8] = '{32'h0, 32'h1, 1'b0, 1'b1,
              32'hFFFF_FFFF, 1'b0, 1'b0};

    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_cin = 1'b0;
    bus.in_sub = 1'b0;
    bus.in_tag = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 128'(bus.out_valid), 0);
    chk("rst_in_ready", 128'(bus.in_ready), 0);
    chk("rst_out_sum", 128'(bus.out_sum), 0);
    chk("rst_out_cout", 128'(bus.out_cout), 0);
    chk("rst_out_ovf", 128'(bus.out_ovf), 0);
    chk("rst_out_tag", 128'(bus.out_tag), 0);
    rst_n = 1'b1;
    go = 1'b1;

    guard = 0;
    while (done != '1 && guard < 40000) begin
      @(negedge clk);
      guard++;
    end
    chk("sweep_done", 128'(done), 128'({NCFG{1'b1}}));

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      beat(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub,
           4'(i), lat, o);
      chk($sformatf("vec%0d_lat", i),
          128'(lat), 128'(LAT));
      chk($sformatf("vec%0d_out", i), 128'(o),
          {vt[i].sum, vt[i].cout, vt[i].ovf, 4'(i)});
    end

    stream(100, 3, 0);
    stream(40, 3, 5);

    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    repeat (10) begin
      bus.in_a = $urandom;
      bus.in_b = $urandom;
      @(negedge clk);
    end
    chk("rst_pre_valid", 128'(bus.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 128'(bus.out_valid), 0);
    chk("rst_mid_ready", 128'(bus.in_ready), 0);
    chk("rst_mid_sum", 128'(bus.out_sum), 0);
    chk("rst_mid_tag", 128'(bus.out_tag), 0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1 seen = seen | bus.out_valid;
    end
    chk("rst_no_stale", 128'(seen), 0);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    beat(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 4'h5,
         lat, o);
    chk("post_rst_lat", 128'(lat), 128'(LAT));
    chk("post_rst_out", 128'(o),
        {32'h0, 1'b1, 1'b0, 4'h5});

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule
